ascon_mgr_arbiter: RTL



---
 rtl/user_pkg.sv | 37 +++
 rtl/ascon_arb_idx_fifo.sv | 65 ++++++
 rtl/ascon_mgr_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/user_pkg.sv
// Shared types for the Ascon manager arbiter.
//   NumAsconMgr       : number of Ascon manager channels sharing the user-domain port
//   AsconArbMaxBurst  : default burst-lock length
//   arb_idx_t         : channel index type
//   mgr_obi_req_t     : OBI request (a-channel + req)
//   mgr_obi_rsp_t     : OBI response (gnt, rvalid, r-channel)
package user_pkg;

  localparam int unsigned NumAsconMgr      = 5;
  localparam int unsigned AsconArbMaxBurst = 4;

  typedef logic [$clog2(NumAsconMgr)-1:0] arb_idx_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/ascon_arb_idx_fifo.sv
// Ordered FIFO of granted channel indices; the head names the channel that owns the
// next downstream response.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : enqueue an index (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   head_o        : oldest index
//   full_o        : Depth entries held
//   empty_o       : no entries held
module ascon_arb_idx_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ascon_mgr_arbiter.sv
// Round-robin arbiter with burst locking that shares the user-domain OBI manager port
// among the Ascon manager channels. Responses are routed back in order via an index FIFO.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_i / rsp_o  : per-channel OBI request / response
//   mgr_req_o      : downstream request (a-channel of the selected channel)
//   mgr_rsp_i      : downstream response
//   busy_o         : transactions outstanding
//   spurious_rsp_o : rvalid received with nothing outstanding (dropped)
//   grant_cnt_o    : per-channel saturating handshake counters, only when
//                    ASCON_ARB_PERF_EN is defined
module ascon_mgr_arbiter
  import user_pkg::*;
#(
  parameter int unsigned NumReq    = NumAsconMgr,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned MaxBurst  = AsconArbMaxBurst,
  parameter type         obi_req_t = mgr_obi_req_t,
  parameter type         obi_rsp_t = mgr_obi_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t [NumReq-1:0]   req_i,
  output obi_rsp_t [NumReq-1:0]   rsp_o,
  output obi_req_t                mgr_req_o,
  input  obi_rsp_t                mgr_rsp_i,
  output logic                    busy_o,
  output logic                    spurious_rsp_o
`ifdef ASCON_ARB_PERF_EN
  ,
  output logic [NumReq-1:0][15:0] grant_cnt_o
`endif
);

  localparam int unsigned IdxW   = $clog2(NumReq);
  localparam int unsigned BurstW = $clog2(MaxBurst + 1);

  logic [NumReq-1:0] req_vec;
  logic              active_q;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic              lock_q, lock_d;
  logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
  logic              hold_q, hold_d;
  logic [IdxW-1:0]   hold_idx_q, hold_idx_d;
  logic [BurstW-1:0] burst_q, burst_d, burst_inc;

  logic              release_lock;
  logic [IdxW-1:0]   ptr_eff, rr_idx, sel;
  logic              rr_found, sel_valid, a_valid, mgr_req_valid, hs;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [IdxW-1:0]   fifo_head;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_vec[i] = req_i[i].req;
    end
  end

  // Selection priority: outstanding un-granted request, then burst lock, then round robin.
  always_comb begin
    logic [IdxW-1:0] cand;
    release_lock = lock_q && !req_vec[lock_idx_q];
    // The pointer a lock release would write is used already in the release cycle.
    ptr_eff  = release_lock ? next_idx(lock_idx_q) : rr_q;
    rr_found = 1'b0;
    rr_idx   = ptr_eff;
    cand     = ptr_eff;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!rr_found && req_vec[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
      cand = next_idx(cand);
    end

    if (hold_q) begin
      sel       = hold_idx_q;
      sel_valid = req_vec[hold_idx_q];
    end else if (lock_q && !release_lock) begin
      sel       = lock_idx_q;
      sel_valid = 1'b1;
    end else begin
      sel       = rr_idx;
      sel_valid = rr_found;
    end
  end

  // active_q keeps the port quiet in the cycle that leaves reset. The full gate uses the
  // registered count only, so rvalid never reaches mgr_req_o.req combinationally.
  assign a_valid       = active_q && sel_valid;
  assign mgr_req_valid = a_valid && !fifo_full;
  assign hs            = mgr_req_valid && mgr_rsp_i.gnt;
  assign fifo_pop      = mgr_rsp_i.rvalid && !fifo_empty;
  assign busy_o        = !fifo_empty;
  assign spurious_rsp_o = rst_ni && mgr_rsp_i.rvalid && fifo_empty;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    burst_d    = burst_q;
    burst_inc  = '0;

    if (release_lock) begin
      lock_d  = 1'b0;
      rr_d    = next_idx(lock_idx_q);
      burst_d = '0;
    end

    if (hs) begin
      burst_inc = burst_d + BurstW'(1);
      if (burst_inc == BurstW'(MaxBurst)) begin
        lock_d  = 1'b0;
        rr_d    = next_idx(sel);
        burst_d = '0;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = sel;
        burst_d    = burst_inc;
      end
    end

    hold_d     = mgr_req_valid && !mgr_rsp_i.gnt;
    hold_idx_d = sel;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q   <= 1'b0;
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      burst_q    <= '0;
    end else begin
      active_q   <= 1'b1;
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      burst_q    <= burst_d;
    end
  end

  always_comb begin
    mgr_req_o     = '0;
    mgr_req_o.req = mgr_req_valid;
    rsp_o         = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (a_valid && (sel == IdxW'(i))) begin
        mgr_req_o.a = req_i[i].a;
      end
      if (sel == IdxW'(i)) begin
        rsp_o[i].gnt = hs;
      end
      if (fifo_pop && (fifo_head == IdxW'(i))) begin
        rsp_o[i].rvalid = 1'b1;
        rsp_o[i].r      = mgr_rsp_i.r;
      end
    end
  end

  ascon_arb_idx_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef ASCON_ARB_PERF_EN
  logic [NumReq-1:0][15:0] grant_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (hs && (sel == IdxW'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`endif

endmodule
